// File: rtl/frame_buffer_writer_pkg.sv
// Shared types, widths and the iteration-to-colour map for the frame buffer writer.
package frame_buffer_writer_pkg;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] COLOR_INSIDE         = 32'h0000_0000;
  localparam logic [PIX_W-1:0]  DEFAULT_FRAME_PIXELS = 24'd1764000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KICK   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } fbw_state_e;

  // Points that reached the ceiling are inside the set and drawn black.
  function automatic logic [DATA_W-1:0] iter_to_colour(input logic [DATA_W-1:0] iter,
                                                       input logic [DATA_W-1:0] max_iter);
    if (iter >= max_iter) return COLOR_INSIDE;
    return {8'h00, iter[7:0], iter[6:0], 1'b0, ~iter[7:0]};
  endfunction

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Engine stream and frame-memory write port seen by the frame buffer writer.
interface frame_buffer_writer_if #(
  parameter int unsigned ADDR_W = 24
);
  import frame_buffer_writer_pkg::*;

  logic              start_render;
  logic [DATA_W-1:0] eng_data;
  logic              eng_ready;
  logic              eng_frame_rdy;
  logic              send_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_busy;

  modport master (
    output start_render, send_data, mem_addr, mem_wdata, mem_we,
    input  eng_data, eng_ready, eng_frame_rdy, mem_busy
  );

  modport slave (
    input  start_render, send_data, mem_addr, mem_wdata, mem_we,
    output eng_data, eng_ready, eng_frame_rdy, mem_busy
  );
endinterface

// File: rtl/frame_buffer_writer_pixel_fifo.sv
// Skid FIFO between engine and memory; the head word is always presented from a register.
module frame_buffer_writer_pixel_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             hvld_q, hvld_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             load_c;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  // Head refills from storage whenever it is empty or being consumed this edge.
  always_comb begin
    load_c    = (ram_cnt_q != '0) && (!hvld_q || pop_i);
    wptr_d    = wptr_q + AW'(push_i);
    rptr_d    = rptr_q + AW'(load_c);
    ram_cnt_d = ram_cnt_q + CW'(push_i) - CW'(load_c);
    fill_d    = fill_q + CW'(push_i) - CW'(pop_i);
    full_d    = (fill_d == CW'(DEPTH));
    hvld_d    = hvld_q;
    head_d    = head_q;
    if (load_c) begin
      hvld_d = 1'b1;
      head_d = mem_q[rptr_q];
    end else if (pop_i) begin
      hvld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      fill_q    <= '0;
      hvld_q    <= 1'b0;
      full_q    <= 1'b0;
      head_q    <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      fill_q    <= fill_d;
      hvld_q    <= hvld_d;
      full_q    <= full_d;
      head_q    <= head_d;
    end
  end

  assign full_o  = full_q;
  assign empty_o = !hvld_q;
  assign head_o  = head_q;

endmodule

// File: rtl/frame_buffer_writer.sv
// Drains the Mandelbrot engine stream, colours each iteration count and writes one frame to memory.
module frame_buffer_writer
  import frame_buffer_writer_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_go_i,
  input  logic [PIX_W-1:0]      total_pixels_i,
  input  logic [DATA_W-1:0]     max_iter_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  frame_buffer_writer_if.master bus
);

  fbw_state_e        state_q, state_d;
  logic [PIX_W-1:0]  tot_q, tot_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [PIX_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [PIX_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              start_q, done_q, busy_q;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              send_data_c, mem_we_c, push_c, pop_c;

  assign send_data_c = (state_q == S_STREAM) && !fifo_full && (rx_cnt_q < tot_q);
  assign mem_we_c    = !fifo_empty && ((state_q == S_STREAM) || (state_q == S_DRAIN));
  assign push_c      = bus.eng_ready && send_data_c;
  assign pop_c       = mem_we_c && !bus.mem_busy;

  frame_buffer_writer_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .din_i   (iter_to_colour(bus.eng_data, max_q)),
    .pop_i   (pop_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Frame sequencing; the write counter alone decides completion.
  always_comb begin
    state_d  = state_q;
    tot_d    = tot_q;
    max_d    = max_q;
    rx_cnt_d = rx_cnt_q + PIX_W'(push_c);
    wr_cnt_d = wr_cnt_q + PIX_W'(pop_c);
    addr_d   = addr_q + ADDR_W'(pop_c);
    unique case (state_q)
      S_IDLE: begin
        if (frame_go_i) begin
          tot_d    = total_pixels_i;
          max_d    = max_iter_i;
          rx_cnt_d = '0;
          wr_cnt_d = '0;
          addr_d   = BASE_ADDR;
          state_d  = (total_pixels_i == '0) ? S_DONE : S_KICK;
        end
      end
      S_KICK:   state_d = S_STREAM;
      S_STREAM: if (rx_cnt_d == tot_q) state_d = S_DRAIN;
      S_DRAIN:  if (pop_c && (wr_cnt_d == tot_q)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tot_q    <= '0;
      max_q    <= '0;
      rx_cnt_q <= '0;
      wr_cnt_q <= '0;
      addr_q   <= BASE_ADDR;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tot_q    <= tot_d;
      max_q    <= max_d;
      rx_cnt_q <= rx_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      addr_q   <= addr_d;
      start_q  <= (state_d == S_KICK);
      done_q   <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign bus.start_render = start_q;
  assign bus.send_data    = send_data_c;
  assign bus.mem_we       = mem_we_c;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = fifo_head;
  assign busy_o           = busy_q;
  assign frame_done_o     = done_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench: table-driven frames plus backpressure, over-supply, zero, ignore and reset sequences.
module tb_frame_buffer_writer;
  import frame_buffer_writer_pkg::*;

  typedef struct {
    logic [31:0] iter;
    logic [31:0] exp_data;
    logic [23:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_go = 1'b0;
  logic [23:0] total_pixels = '0;
  logic [31:0] max_iter = '0;
  logic        busy, frame_done;

  always #5 clk = ~clk;

  frame_buffer_writer_if #(.ADDR_W(24)) bus ();

  frame_buffer_writer #(
    .ADDR_W     (24),
    .BASE_ADDR  (24'h000000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_go_i     (frame_go),
    .total_pixels_i (total_pixels),
    .max_iter_i     (max_iter),
    .busy_o         (busy),
    .frame_done_o   (frame_done),
    .bus            (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] src [16];
  int src_n = 0, src_idx = 0;
  int cyc = 0, xfer_cnt = 0, wr_n = 0, start_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic [31:0] wr_data [256];
  logic [23:0] wr_addr [256];
  int          wr_cyc  [256];
  int          xfer_cyc[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Engine model and write/handshake logger; inputs change on negedge, handshakes judged just after.
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      bus.eng_ready = (src_idx < src_n);
      bus.eng_data  = (src_idx < src_n) ? src[src_idx] : 32'h0;
      #1;
      if (bus.eng_ready && bus.send_data) begin
        xfer_cyc[xfer_cnt % 256] = cyc;
        xfer_cnt++;
        src_idx++;
      end
      if (bus.mem_we && !bus.mem_busy) begin
        wr_data[wr_n % 256] = bus.mem_wdata;
        wr_addr[wr_n % 256] = bus.mem_addr;
        wr_cyc[wr_n % 256]  = cyc;
        wr_n++;
      end
      if (bus.start_render) start_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic go(input logic [23:0] tp, input logic [31:0] mi);
    @(negedge clk);
    frame_go     = 1'b1;
    total_pixels = tp;
    max_iter     = mi;
    @(negedge clk);
    frame_go = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      @(negedge clk);
      #2;
    end
    check(name, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  function automatic logic [31:0] colour(input logic [31:0] it, input logic [31:0] mx);
    if (it >= mx) return 32'h0;
    return {8'h00, it[7:0], it[6:0], 1'b0, ~it[7:0]};
  endfunction

  vec_t basic [4];
  vec_t cvec  [8];
  logic [31:0] bp_src [8];

  initial begin
    int wr0, x0, s0, d0, bad;

    basic[0] = '{32'd3,   32'h0003_06FC, 24'd0};
    basic[1] = '{32'd255, 32'h0000_0000, 24'd1};
    basic[2] = '{32'd0,   32'h0000_00FF, 24'd2};
    basic[3] = '{32'd300, 32'h0000_0000, 24'd3};

    cvec[0] = '{32'd3,         32'h0003_06FC, 24'd0};
    cvec[1] = '{32'd255,       32'h00FF_FE00, 24'd1};
    cvec[2] = '{32'd0,         32'h0000_00FF, 24'd2};
    cvec[3] = '{32'd300,       32'h002C_58D3, 24'd3};
    cvec[4] = '{32'd511,       32'h00FF_FE00, 24'd4};
    cvec[5] = '{32'd512,       32'h0000_0000, 24'd5};
    cvec[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 24'd6};
    cvec[7] = '{32'd128,       32'h0080_007F, 24'd7};

    bp_src = '{32'd5, 32'd199, 32'd200, 32'd17, 32'd255, 32'd100, 32'd0, 32'd64};

    bus.eng_data      = '0;
    bus.eng_ready     = 1'b0;
    bus.eng_frame_rdy = 1'b0;
    bus.mem_busy      = 1'b0;
    fork monitor(); join_none

    // Reset state
    idle_cycles(3);
    check("rst_start_render", 32'(bus.start_render), 32'd0);
    check("rst_send_data",    32'(bus.send_data), 32'd0);
    check("rst_mem_we",       32'(bus.mem_we), 32'd0);
    check("rst_mem_addr",     32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata",    bus.mem_wdata, 32'd0);
    check("rst_busy",         32'(busy), 32'd0);
    check("rst_frame_done",   32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (busy || frame_done || bus.start_render || bus.mem_we || bus.send_data) bad++;
    end
    check("idle_hold", 32'(bad), 32'd0);

    // Basic frame
    for (int i = 0; i < 4; i++) src[i] = basic[i].iter;
    src_idx = 0; src_n = 4;
    wr0 = wr_n; x0 = xfer_cnt; s0 = start_cnt; d0 = done_cnt;
    go(24'd4, 32'd255);
    wait_done("basic_done_timeout", d0, 100);
    check("basic_start_pulses", 32'(start_cnt - s0), 32'd1);
    check("basic_writes", 32'(wr_n - wr0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_data[%0d]", i), wr_data[wr0 + i], basic[i].exp_data);
      check($sformatf("basic_addr[%0d]", i), 32'(wr_addr[wr0 + i]), 32'(basic[i].exp_addr));
    end
    check("basic_latency", 32'(wr_cyc[wr0] - xfer_cyc[x0]), 32'd2);
    check("basic_done_after_last", 32'(done_cyc - wr_cyc[wr0 + 3]), 32'd1);
    idle_cycles(2);
    check("basic_idle_after", 32'(busy), 32'd0);

    // Colour map table, unsigned compare against a wider ceiling
    for (int i = 0; i < 8; i++) src[i] = cvec[i].iter;
    src_idx = 0; src_n = 8;
    wr0 = wr_n; d0 = done_cnt;
    go(24'd8, 32'd512);
    wait_done("colour_done_timeout", d0, 100);
    check("colour_writes", 32'(wr_n - wr0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("colour_data[%0d]", i), wr_data[wr0 + i], cvec[i].exp_data);
      check($sformatf("colour_addr[%0d]", i), 32'(wr_addr[wr0 + i]), 32'(cvec[i].exp_addr));
    end

    // Backpressure: memory stalled while the engine streams
    for (int i = 0; i < 8; i++) src[i] = bp_src[i];
    src_idx = 0; src_n = 8;
    wr0 = wr_n; x0 = xfer_cnt; d0 = done_cnt;
    @(negedge clk);
    bus.mem_busy = 1'b1;
    go(24'd8, 32'd200);
    idle_cycles(10);
    check("bp_xfers_when_full", 32'(xfer_cnt - x0), 32'd4);
    check("bp_send_data_low", 32'(bus.send_data), 32'd0);
    check("bp_we_held", 32'(bus.mem_we), 32'd1);
    check("bp_addr_held", 32'(bus.mem_addr), 32'd0);
    check("bp_data_held", bus.mem_wdata, colour(bp_src[0], 32'd200));
    @(negedge clk);
    bus.mem_busy = 1'b0;
    wait_done("bp_done_timeout", d0, 100);
    check("bp_xfers", 32'(xfer_cnt - x0), 32'd8);
    check("bp_writes", 32'(wr_n - wr0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_data[%0d]", i), wr_data[wr0 + i], colour(bp_src[i], 32'd200));
      check($sformatf("bp_addr[%0d]", i), 32'(wr_addr[wr0 + i]), 32'(i));
    end

    // Over-supply: engine keeps offering words past the frame size
    for (int i = 0; i < 6; i++) src[i] = 32'(i + 1);
    src_idx = 0; src_n = 6;
    wr0 = wr_n; x0 = xfer_cnt; d0 = done_cnt;
    bus.eng_frame_rdy = 1'b1;
    go(24'd2, 32'd255);
    wait_done("over_done_timeout", d0, 100);
    idle_cycles(5);
    check("over_xfers", 32'(xfer_cnt - x0), 32'd2);
    check("over_writes", 32'(wr_n - wr0), 32'd2);
    check("over_send_low", 32'(bus.send_data), 32'd0);
    src_n = 0;
    bus.eng_frame_rdy = 1'b0;

    // Zero-size frame
    wr0 = wr_n; s0 = start_cnt; d0 = done_cnt;
    go(24'd0, 32'd255);
    wait_done("zero_done_timeout", d0, 20);
    idle_cycles(3);
    check("zero_start", 32'(start_cnt - s0), 32'd0);
    check("zero_writes", 32'(wr_n - wr0), 32'd0);
    check("zero_done_pulses", 32'(done_cnt - d0), 32'd1);

    // frame_go while busy is ignored
    for (int i = 0; i < 4; i++) src[i] = 32'(10 + i);
    src_idx = 0; src_n = 4;
    wr0 = wr_n; s0 = start_cnt; d0 = done_cnt;
    bus.mem_busy = 1'b1;
    go(24'd4, 32'd255);
    idle_cycles(2);
    go(24'd9, 32'd255);
    bus.mem_busy = 1'b0;
    wait_done("ignore_done_timeout", d0, 100);
    idle_cycles(10);
    check("ignore_start", 32'(start_cnt - s0), 32'd1);
    check("ignore_writes", 32'(wr_n - wr0), 32'd4);
    check("ignore_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("ignore_idle", 32'(busy), 32'd0);

    // Reset mid-frame
    for (int i = 0; i < 8; i++) src[i] = 32'(20 + i);
    src_idx = 0; src_n = 8;
    x0 = xfer_cnt;
    bus.mem_busy = 1'b1;
    go(24'd8, 32'd255);
    for (int i = 0; i < 50 && (xfer_cnt - x0) < 2; i++) idle_cycles(1);
    check("mid_reached_2", 32'((xfer_cnt - x0) >= 2), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_send", 32'(bus.send_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    check("mid_rst_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_busy = 1'b0;
    src_n = 0;
    wr0 = wr_n;
    idle_cycles(5);
    check("mid_no_stale_writes", 32'(wr_n - wr0), 32'd0);
    src[0] = 32'd7; src[1] = 32'd8;
    src_idx = 0; src_n = 2;
    d0 = done_cnt;
    go(24'd2, 32'd255);
    wait_done("mid_restart_timeout", d0, 100);
    check("mid_restart_writes", 32'(wr_n - wr0), 32'd2);
    check("mid_restart_addr0", 32'(wr_addr[wr0]), 32'd0);
    check("mid_restart_addr1", 32'(wr_addr[wr0 + 1]), 32'd1);
    check("mid_restart_data0", wr_data[wr0], 32'h0007_0EF8);
    check("mid_restart_data1", wr_data[wr0 + 1], 32'h0008_10F7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
